// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake FSM with timeout, stall generation and the
// MEM/WB register. A halt retiring through WB blocks all further memory traffic.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_pcs,
  input  logic        ex_hlt,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_write_data,
  input  logic [15:0] ex_pc,
  input  logic [3:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic        wb_hlt,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        halted,
  output logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam logic [8:0] TLIM = 9'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  cnt_inc;
  logic        memop;
  logic        wb_load;
  logic [15:0] wb_data_d;

  assign memop     = (ex_memread | ex_memwrite) & ~halted;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign mem_we    = mem_req & ex_memwrite;
  assign mem_addr  = ex_alu_out;
  assign mem_wdata = ex_write_data;
  assign mem_err   = (state_q == ERR);
  assign wb_load   = ~stall & (state_q != ERR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_req = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          mem_req = 1'b1;
          if (!mem_ack) begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = 8'd0;
          end
        end
      end
      BUSY: begin
        // A halt that retires while a request is in flight drops the request.
        if (halted) begin
          state_d = IDLE;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            state_d = IDLE;
          end else begin
            stall = 1'b1;
            if (cnt_inc >= TLIM) begin
              state_d = ERR;
            end else begin
              cnt_d = cnt_inc[7:0];
            end
          end
        end
      end
      ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    if (ex_memtoreg) begin
      wb_data_d = mem_rdata;
    end else if (ex_pcs) begin
      wb_data_d = ex_pc;
    end else begin
      wb_data_d = ex_alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      halted      <= 1'b0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_hlt      <= 1'b0;
      wb_data     <= 16'd0;
      wb_rd       <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halted  <= halted | wb_hlt;
      if (wb_load) begin
        wb_valid    <= 1'b1;
        wb_regwrite <= ex_regwrite & ~halted;
        wb_hlt      <= ex_hlt;
        wb_data     <= wb_data_d;
        wb_rd       <= ex_rd;
      end else begin
        wb_valid    <= 1'b0;
        wb_regwrite <= 1'b0;
        wb_hlt      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage; a transaction-level model predicts handshake,
// stall and MEM/WB results.
module tb_mem_stage;
  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_pcs, ex_hlt;
  logic [15:0] ex_alu_out, ex_write_data, ex_pc;
  logic [3:0]  ex_rd;
  logic        mem_req, mem_we, mem_ack, stall;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, wb_regwrite, wb_hlt, halted, mem_err;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_pcs(ex_pcs), .ex_hlt(ex_hlt),
    .ex_alu_out(ex_alu_out), .ex_write_data(ex_write_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_hlt(wb_hlt),
    .wb_data(wb_data), .wb_rd(wb_rd), .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: what the MEM/WB register and halt flag should hold.
  bit          halted_m;
  bit          m_hlt;
  logic [15:0] m_data;
  logic [3:0]  m_rd;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    {ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_pcs, ex_hlt} = 6'b0;
    ex_alu_out = 16'd0; ex_write_data = 16'd0; ex_pc = 16'd0; ex_rd = 4'd0;
    mem_ack = 1'b0; mem_rdata = 16'd0;
  endtask

  // Clock edge: halt latches from the previous wb_hlt, then wb_hlt reflects this cycle.
  task automatic tick(input bit load, input bit hlt_in);
    @(posedge clk);
    #1;
    halted_m = halted_m | m_hlt;
    m_hlt    = load ? hlt_in : 1'b0;
    check1("halted", halted, halted_m);
  endtask

  task automatic do_reset(input logic ack_during);
    @(negedge clk);
    rst = 1'b1;
    zero_inputs();
    mem_ack = ack_during;
    @(posedge clk);
    @(posedge clk);
    #1;
    halted_m = 0; m_hlt = 0; m_data = 16'd0; m_rd = 4'd0;
    check1("rst_wb_valid", wb_valid, 1'b0);
    check1("rst_wb_regwrite", wb_regwrite, 1'b0);
    check1("rst_wb_hlt", wb_hlt, 1'b0);
    check16("rst_wb_data", wb_data, 16'd0);
    check16("rst_wb_rd", {12'd0, wb_rd}, 16'd0);
    check1("rst_halted", halted, 1'b0);
    check1("rst_mem_err", mem_err, 1'b0);
    rst = 1'b0;
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check1("rst_stall", stall, 1'b0);
    check16("rst_mem_addr", mem_addr, 16'd0);
  endtask

  // One EX/MEM instruction; memory acks 'delay' cycles after the request is first raised.
  task automatic do_op(input string name, input bit rw, input bit mtr, input bit mr,
                       input bit mw, input bit pcs, input bit hlt, input logic [15:0] alu,
                       input logic [15:0] wd, input logic [15:0] pc, input logic [3:0] rd,
                       input int delay, input logic [15:0] rdata);
    bit memop, stl, hb;
    int dly;
    int k;
    @(negedge clk);
    ex_regwrite = rw; ex_memtoreg = mtr; ex_memread = mr; ex_memwrite = mw;
    ex_pcs = pcs; ex_hlt = hlt; ex_alu_out = alu; ex_write_data = wd; ex_pc = pc; ex_rd = rd;
    hb    = halted_m;
    memop = (mr || mw) && !hb;
    dly   = memop ? delay : 0;
    k     = 0;
    forever begin
      mem_ack   = (k == dly);
      mem_rdata = mem_ack ? rdata : 16'($urandom);
      #1;
      stl = memop && (k < dly);
      check1({name, "_req"}, mem_req, memop);
      check1({name, "_we"}, mem_we, memop && mw);
      check1({name, "_stall"}, stall, stl);
      if (memop) begin
        check16({name, "_addr"}, mem_addr, alu);
        check16({name, "_wdata"}, mem_wdata, wd);
      end
      tick(!stl, hlt);
      if (!stl) break;
      check1({name, "_bub_valid"}, wb_valid, 1'b0);
      check1({name, "_bub_regwrite"}, wb_regwrite, 1'b0);
      check1({name, "_bub_hlt"}, wb_hlt, 1'b0);
      check16({name, "_bub_data"}, wb_data, m_data);
      check16({name, "_bub_rd"}, {12'd0, wb_rd}, {12'd0, m_rd});
      k++;
      @(negedge clk);
    end
    m_data = mtr ? rdata : (pcs ? pc : alu);
    m_rd   = rd;
    check1({name, "_wb_valid"}, wb_valid, 1'b1);
    check1({name, "_wb_regwrite"}, wb_regwrite, rw && !hb);
    check1({name, "_wb_hlt"}, wb_hlt, m_hlt);
    check16({name, "_wb_data"}, wb_data, m_data);
    check16({name, "_wb_rd"}, {12'd0, wb_rd}, {12'd0, m_rd});
  endtask

  initial begin
    int n;
    rst = 1'b1;
    zero_inputs();
    do_reset(1'b0);

    do_op("alu", 1, 0, 0, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 4'd3, 0, 16'h0);
    do_op("load3", 1, 1, 1, 0, 0, 0, 16'h0040, 16'h0, 16'h0, 4'd5, 3, 16'hBEEF);
    do_op("store", 0, 0, 0, 1, 0, 0, 16'h0010, 16'h00AA, 16'h0, 4'd2, 0, 16'h0);
    do_op("pcs", 1, 0, 0, 0, 1, 0, 16'h7777, 16'h0, 16'h0102, 4'd15, 0, 16'h0);
    do_op("pcs_mtr", 1, 1, 1, 0, 1, 0, 16'h0080, 16'h0, 16'h0102, 4'd14, 1, 16'h5555);
    do_op("rw_both", 1, 0, 1, 1, 0, 0, 16'h0abc, 16'h1111, 16'h0, 4'd1, 2, 16'h0);

    for (int i = 0; i < 40; i++) begin
      do_op("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
            int'($urandom_range(0, 4)), 16'($urandom));
    end

    do_op("hlt", 1, 0, 0, 0, 0, 1, 16'h0bad, 16'h0, 16'h0, 4'd7, 0, 16'h0);
    do_op("post_hlt_nop", 1, 0, 0, 0, 0, 0, 16'h0001, 16'h0, 16'h0, 4'd8, 0, 16'h0);
    check1("halted_set", halted, 1'b1);
    do_op("halted_load", 1, 1, 1, 0, 0, 0, 16'h0040, 16'h0, 16'h0, 4'd9, 3, 16'h1357);
    do_op("halted_store", 1, 0, 0, 1, 0, 0, 16'h0044, 16'h2468, 16'h0, 4'd10, 2, 16'h0);
    check1("halted_sticky", halted, 1'b1);

    do_reset(1'b0);
    // Abandon an outstanding request with reset; a late ack must be ignored.
    @(negedge clk);
    ex_memread = 1'b1; ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_alu_out = 16'h0200;
    repeat (3) @(posedge clk);
    #1;
    check1("midreq_stall", stall, 1'b1);
    do_reset(1'b1);
    @(posedge clk);
    #1;
    check1("post_rst_ack_req", mem_req, 1'b0);
    check1("post_rst_ack_stall", stall, 1'b0);
    check1("post_rst_ack_err", mem_err, 1'b0);

    do_reset(1'b0);
    @(negedge clk);
    ex_memread = 1'b1; ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_alu_out = 16'h0300;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (mem_err) break;
      check1("to_wait_stall", stall, 1'b1);
    end
    check16("timeout_cycles", 16'(n), 16'(TIMEOUT + 1));
    check1("err_flag", mem_err, 1'b1);
    check1("err_stall", stall, 1'b1);
    check1("err_req", mem_req, 1'b0);
    check1("err_we", mem_we, 1'b0);
    check1("err_wb_valid", wb_valid, 1'b0);
    check1("err_wb_regwrite", wb_regwrite, 1'b0);
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("err_absorbing", mem_err, 1'b1);
    check1("err_absorbing_stall", stall, 1'b1);
    check1("err_absorbing_valid", wb_valid, 1'b0);
    do_reset(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL: parameter TIMEOUT, default 255, max cycles waited for mem_ack before error.
REQ-002 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL: ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_pcs, ex_hlt  input  1 each  control bits from EX/MEM register.
REQ-005 SHALL: ex_alu_out, ex_write_data, ex_pc  input  16 each  ALU result/address, store data, PC for PCS.
REQ-006 SHALL: ex_rd  input  4  destination register.
REQ-007 SHALL: mem_req  output  1  data-memory request; mem_we  output  1  write strobe.
REQ-008 SHALL: mem_addr, mem_wdata  output  16 each  address and store data.
REQ-009 SHALL: mem_ack  input  1  memory completion; mem_rdata  input  16  load data, valid when mem_ack=1.
REQ-010 SHALL: stall  output  1  freeze request to IF/ID/EX and the EX/MEM register.
REQ-011 SHALL: wb_valid, wb_regwrite, wb_hlt  output  1 each; wb_data  output  16; wb_rd  output  4  registered MEM/WB outputs.
REQ-012 SHALL: halted  output  1  sticky halt; mem_err  output  1  sticky timeout error.

Function
REQ-013 SHALL: memory op = ex_memread OR ex_memwrite; ex_memwrite has priority if both set (mem_we=1).
REQ-014 SHALL: FSM states IDLE, BUSY, ERR; reset state IDLE.
REQ-015 SHALL: IDLE with memory op: mem_req=1 combinationally; mem_ack same cycle -> stay IDLE, stall=0; else -> BUSY, stall=1.
REQ-016 SHALL: BUSY: mem_req=1, stall=1 until the mem_ack cycle; that cycle stall=0, next state IDLE.
REQ-017 SHALL: mem_addr=ex_alu_out, mem_wdata=ex_write_data, mem_we stable for the whole request; inputs assumed held by upstream while stall=1.
REQ-018 SHALL: mem_req=0, mem_we=0 in IDLE without memory op, and in ERR.
REQ-019 SHALL: 8-bit wait counter cleared on entering BUSY, incremented each BUSY cycle without ack; reaching TIMEOUT -> ERR, mem_err=1.
REQ-020 SHALL: ERR absorbing until rst; stall=1, wb_valid=0, wb_regwrite=0 in ERR.
REQ-021 SHALL: MEM/WB register loads when stall=0 and state is not ERR; latency 1 cycle after op completion.
REQ-022 SHALL: wb_data = mem_rdata if ex_memtoreg, else ex_pc if ex_pcs, else ex_alu_out (priority in that order).
REQ-023 SHALL: on load, wb_valid=1, wb_regwrite=ex_regwrite, wb_rd=ex_rd, wb_hlt=ex_hlt.
REQ-024 SHALL: on any cycle with stall=1, next wb_valid=0, wb_regwrite=0, wb_hlt=0 (bubble); wb_data/wb_rd hold.
REQ-025 SHALL: halted set the cycle after wb_hlt=1 loads; once set, mem_req forced 0 and wb_regwrite forced 0 on later loads.
REQ-026 SHALL: store (ex_memwrite) never writes the register file unless ex_regwrite=1; no state change beyond the handshake.

Reset
REQ-027 SHALL: rst=1 at an edge -> state IDLE, counter 0, all wb_* 0, halted 0, mem_err 0, regardless of an outstanding request.
REQ-028 SHALL: mem_req, mem_we, stall = 0 in the cycle after reset; a mem_ack arriving after reset mid-request is ignored in IDLE without memory op.

Verification
REQ-029 SHALL: ALU op, ex_alu_out=0x1234, ex_rd=3, ex_regwrite=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, stall never 1.
REQ-030 SHALL: load addr 0x0040, mem_ack 3 cycles later with rdata 0xBEEF -> stall=1 for 3 cycles, three bubbles, then wb_data=0xBEEF, wb_regwrite=1.
REQ-031 SHALL: store addr 0x0010 data 0x00AA, zero-wait ack -> mem_we=1, stall=0, wb_regwrite=0, wb_valid=1.
REQ-032 SHALL: PCS with ex_pc=0x0102 -> wb_data=0x0102; with memtoreg also set and rdata 0x5555 -> wb_data=0x5555.
REQ-033 SHALL: load, no ack for TIMEOUT=255 cycles -> mem_err=1, stall stays 1, mem_req=0; rst -> all outputs 0.
REQ-034 SHALL: HLT op -> wb_hlt=1 one cycle, halted=1 next cycle and sticky; subsequent load issues no mem_req.
